// File: rtl/regfile_mp_sb_if.sv
// Bus interface for the multi-port register file with pending-write scoreboard.
// The master modport belongs to the decode/write-back side and the slave modport
// belongs to the register file itself.
interface regfile_mp_sb_if #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_REGS = 15,
    parameter int NUM_RD   = 3
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    logic                     wb0_en;
    logic [ADDR_W-1:0]        wb0_dest;
    logic [DATA_W-1:0]        wb0_val;
    logic                     wb1_en;
    logic [ADDR_W-1:0]        wb1_dest;
    logic [DATA_W-1:0]        wb1_val;

    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_dest;
    logic                     flush;

    logic [NUM_REGS-1:0]      pend_vec;
    logic                     any_pend;
    logic                     sb_err;

    modport master (
        output rd_addr, wb0_en, wb0_dest, wb0_val, wb1_en, wb1_dest, wb1_val,
               iss_en, iss_dest, flush,
        input  rd_data, rd_busy, pend_vec, any_pend, sb_err
    );

    modport slave (
        input  rd_addr, wb0_en, wb0_dest, wb0_val, wb1_en, wb1_dest, wb1_val,
               iss_en, iss_dest, flush,
        output rd_data, rd_busy, pend_vec, any_pend, sb_err
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with two prioritised write-back lanes and a
// per-register 2-bit pending-write scoreboard. Register 15 (PC) lives elsewhere.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write-back
// data to the read ports and discount same-cycle retirements from rd_busy.
module regfile_mp_sb #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 4,
    parameter int NUM_REGS    = 15,
    parameter int NUM_RD      = 3,
    parameter int RESET_INDEX = 1
) (
    input logic            clk,
    input logic            rst,
    regfile_mp_sb_if.slave bus
);
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [1:0]          r_cnt  [NUM_REGS];
    logic                r_sbErr;

    logic [1:0]          w_cntNext [NUM_REGS];
    logic [NUM_REGS-1:0] w_errVec;
    logic [NUM_REGS-1:0] w_pendVec;
    logic [NUM_RD*DATA_W-1:0] w_rdData;
    logic [NUM_RD-1:0]   w_rdBusy;

    // Register storage: lane 1 is applied after lane 0 so it wins on a shared destination
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= (RESET_INDEX != 0) ? DATA_W'(i) : '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (bus.wb1_en && bus.wb1_dest == ADDR_W'(i)) begin
                    r_regs[i] <= bus.wb1_val;
                end else if (bus.wb0_en && bus.wb0_dest == ADDR_W'(i)) begin
                    r_regs[i] <= bus.wb0_val;
                end
            end
        end
    end

    // Scoreboard arithmetic: cnt + issue - retirements, clamped to 0..3 with an error flag
    always_comb begin
        int sum;
        int inc;
        int dec;
        sum = 0;
        inc = 0;
        dec = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc = (bus.iss_en && bus.iss_dest == ADDR_W'(i)) ? 1 : 0;
            dec = ((bus.wb0_en && bus.wb0_dest == ADDR_W'(i)) ? 1 : 0)
                + ((bus.wb1_en && bus.wb1_dest == ADDR_W'(i)) ? 1 : 0);
            sum = int'(r_cnt[i]) + inc - dec;
            w_errVec[i]  = 1'b0;
            w_cntNext[i] = r_cnt[i];
            if (sum > 3) begin
                w_cntNext[i] = 2'd3;
                w_errVec[i]  = 1'b1;
            end else if (sum < 0) begin
                w_cntNext[i] = 2'd0;
                w_errVec[i]  = 1'b1;
            end else begin
                w_cntNext[i] = sum[1:0];
            end
        end
    end

    // Scoreboard state: flush discards the cycle's counter effects and never raises the error
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= 2'd0;
            end
            r_sbErr <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_cnt[i] <= w_cntNext[i];
            end
            r_sbErr <= r_sbErr | (|w_errVec);
        end
    end

    // Pending summary for the hazard unit
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pendVec[i] = (r_cnt[i] != 2'd0);
        end
    end

    genvar k;
    generate
        for (k = 0; k < NUM_RD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_inRange;
            logic [DATA_W-1:0] w_data;
            logic              w_busy;

            assign w_addr    = bus.rd_addr[k*ADDR_W +: ADDR_W];
            assign w_inRange = ({1'b0, w_addr} < NUM_REGS_W);

            // Combinational read port; out-of-range addresses read as zero and never busy
            always_comb begin
                w_data = '0;
                w_busy = 1'b0;
                if (w_inRange) begin
`ifdef REGFILE_BYPASS_EN
                    logic       w_hit0;
                    logic       w_hit1;
                    logic [2:0] w_matches;
                    w_hit0    = bus.wb0_en && (bus.wb0_dest == w_addr);
                    w_hit1    = bus.wb1_en && (bus.wb1_dest == w_addr);
                    w_matches = {2'b00, w_hit0} + {2'b00, w_hit1};
                    if (w_hit1) begin
                        w_data = bus.wb1_val;
                    end else if (w_hit0) begin
                        w_data = bus.wb0_val;
                    end else begin
                        w_data = r_regs[w_addr];
                    end
                    w_busy = ({1'b0, r_cnt[w_addr]} > w_matches);
`else
                    w_data = r_regs[w_addr];
                    w_busy = (r_cnt[w_addr] != 2'd0);
`endif
                end
            end

            assign w_rdData[k*DATA_W +: DATA_W] = w_data;
            assign w_rdBusy[k]                  = w_busy;
        end
    endgenerate

    assign bus.rd_data  = w_rdData;
    assign bus.rd_busy  = w_rdBusy;
    assign bus.pend_vec = w_pendVec;
    assign bus.any_pend = |w_pendVec;
    assign bus.sb_err   = r_sbErr;
endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed scenarios followed by random
// traffic, all compared against a behavioural model of the register file.
module tb_regfile_mp_sb;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int NR = 15;
    localparam int RD = 3;

    logic clk;
    logic rst;

    regfile_mp_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD)) bus ();

    regfile_mp_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(RD), .RESET_INDEX(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0] modelReg [NR];
    int            modelCnt [NR];
    logic          modelErr;
    int            checkCount;
    int            passCount;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) begin
            modelReg[i] = DW'(i);
            modelCnt[i] = 0;
        end
        modelErr = 1'b0;
    endtask

    task automatic modelEdge(input logic w0e, input logic [AW-1:0] w0d, input logic [DW-1:0] w0v,
                             input logic w1e, input logic [AW-1:0] w1d, input logic [DW-1:0] w1v,
                             input logic ie, input logic [AW-1:0] id, input logic fl);
        int delta;
        int n;
        if (w0e && int'(w0d) < NR) modelReg[w0d] = w0v;
        if (w1e && int'(w1d) < NR) modelReg[w1d] = w1v;
        for (int i = 0; i < NR; i++) begin
            if (fl) begin
                modelCnt[i] = 0;
            end else begin
                delta = 0;
                if (ie && int'(id) == i) delta++;
                if (w0e && int'(w0d) == i) delta--;
                if (w1e && int'(w1d) == i) delta--;
                n = modelCnt[i] + delta;
                if (n > 3) begin
                    n = 3;
                    modelErr = 1'b1;
                end else if (n < 0) begin
                    n = 0;
                    modelErr = 1'b1;
                end
                modelCnt[i] = n;
            end
        end
    endtask

    task automatic checkReads(input logic [RD*AW-1:0] ra);
        logic [AW-1:0] a;
        logic [DW-1:0] expData;
        logic          expBusy;
        int            pending;
        for (int k = 0; k < RD; k++) begin
            a       = ra[k*AW +: AW];
            expData = '0;
            expBusy = 1'b0;
            if (int'(a) < NR) begin
                expData = modelReg[a];
                pending = modelCnt[a];
`ifdef REGFILE_BYPASS_EN
                if (bus.wb1_en && bus.wb1_dest == a) expData = bus.wb1_val;
                else if (bus.wb0_en && bus.wb0_dest == a) expData = bus.wb0_val;
                if (bus.wb0_en && bus.wb0_dest == a) pending--;
                if (bus.wb1_en && bus.wb1_dest == a) pending--;
`endif
                expBusy = (pending > 0);
            end
            checkOutput($sformatf("rd_data%0d@r%0d", k, a), 128'(bus.rd_data[k*DW +: DW]), 128'(expData));
            checkOutput($sformatf("rd_busy%0d@r%0d", k, a), 128'(bus.rd_busy[k]), 128'(expBusy));
        end
    endtask

    task automatic checkState();
        logic [NR-1:0] expPend;
        for (int i = 0; i < NR; i++) expPend[i] = (modelCnt[i] != 0);
        checkOutput("pend_vec", 128'(bus.pend_vec), 128'(expPend));
        checkOutput("any_pend", 128'(bus.any_pend), 128'(|expPend));
        checkOutput("sb_err", 128'(bus.sb_err), 128'(modelErr));
    endtask

    task automatic applyStimulus(input logic w0e, input logic [AW-1:0] w0d, input logic [DW-1:0] w0v,
                                 input logic w1e, input logic [AW-1:0] w1d, input logic [DW-1:0] w1v,
                                 input logic ie, input logic [AW-1:0] id, input logic fl,
                                 input logic [RD*AW-1:0] ra);
        bus.wb0_en   = w0e;
        bus.wb0_dest = w0d;
        bus.wb0_val  = w0v;
        bus.wb1_en   = w1e;
        bus.wb1_dest = w1d;
        bus.wb1_val  = w1v;
        bus.iss_en   = ie;
        bus.iss_dest = id;
        bus.flush    = fl;
        bus.rd_addr  = ra;
        #1;
        checkReads(ra);
        @(posedge clk);
        modelEdge(w0e, w0d, w0v, w1e, w1d, w1v, ie, id, fl);
        #1;
        checkState();
    endtask

    task automatic idleInputs(input logic [RD*AW-1:0] ra);
        bus.wb0_en = 1'b0; bus.wb0_dest = '0; bus.wb0_val = '0;
        bus.wb1_en = 1'b0; bus.wb1_dest = '0; bus.wb1_val = '0;
        bus.iss_en = 1'b0; bus.iss_dest = '0; bus.flush = 1'b0;
        bus.rd_addr = ra;
    endtask

    task automatic doReset();
        idleInputs('0);
        rst = 1'b1;
        @(posedge clk);
        modelReset();
        #1;
        rst = 1'b0;
        checkState();
    endtask

    task automatic idleStep(input logic [RD*AW-1:0] ra);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, ra);
    endtask

    initial begin
        logic [RD*AW-1:0] ra;
        checkCount = 0;
        passCount  = 0;
        rst        = 1'b1;
        idleInputs('0);
        #1;
        doReset();

        // Reset values visible on all ports: r0..r14 plus out-of-range r15
        for (int b = 0; b < 16; b += 3) begin
            ra = {AW'((b + 2) % 16), AW'((b + 1) % 16), AW'(b)};
            idleStep(ra);
        end

        // Dual write to the same register: lane 1 wins
        applyStimulus(1'b1, 4'd3, 32'hAAAA0000, 1'b1, 4'd3, 32'h5555FFFF, 1'b0, '0, 1'b0, {4'd3, 4'd3, 4'd3});
        idleInputs({4'd0, 4'd0, 4'd3});
        #1;
        checkOutput("r3_lane1_wins", 128'(bus.rd_data[DW-1:0]), 128'(32'h5555FFFF));
        applyStimulus(1'b1, 4'd4, 32'h00000011, 1'b1, 4'd6, 32'h00000022, 1'b0, '0, 1'b0, {4'd6, 4'd4, 4'd3});
        idleStep({4'd6, 4'd4, 4'd3});

        // Fresh scoreboard: saturate r5, drain it, then underflow
        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd5, 1'b0, {4'd0, 4'd0, 4'd5});
        idleInputs({4'd0, 4'd0, 4'd5});
        #1;
        checkOutput("r5_busy_cnt3", 128'(bus.rd_busy[0]), 128'(1'b1));
        checkOutput("sb_err_before_ovf", 128'(bus.sb_err), 128'(1'b0));
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd5, 1'b0, {4'd0, 4'd0, 4'd5});
        checkOutput("sb_err_ovf", 128'(bus.sb_err), 128'(1'b1));
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'd5, DW'(100 + i), 1'b0, '0, '0, 1'b0, '0, 1'b0, {4'd0, 4'd0, 4'd5});
        checkOutput("pend5_drained", 128'(bus.pend_vec[5]), 128'(1'b0));
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 32'h55, 1'b0, '0, 1'b0, {4'd0, 4'd0, 4'd5});
        checkOutput("pend5_clamped", 128'(bus.pend_vec[5]), 128'(1'b0));
        checkOutput("sb_err_sticky", 128'(bus.sb_err), 128'(1'b1));

        // Issue and retire r7 in the same cycle keeps cnt at 1
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7, 1'b0, {4'd0, 4'd0, 4'd7});
        applyStimulus(1'b1, 4'd7, 32'h77, 1'b0, '0, '0, 1'b1, 4'd7, 1'b0, {4'd0, 4'd0, 4'd7});
        checkOutput("pend7_net0", 128'(bus.pend_vec[7]), 128'(1'b1));

        // Flush with r2 pending twice clears everything
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd2, 1'b0, {4'd0, 4'd7, 4'd2});
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd2, 1'b0, {4'd0, 4'd7, 4'd2});
        applyStimulus(1'b1, 4'd2, 32'hF00D, 1'b0, '0, '0, 1'b1, 4'd2, 1'b1, {4'd0, 4'd7, 4'd2});
        checkOutput("flush_any_pend", 128'(bus.any_pend), 128'(1'b0));

        // Write-through (or not) on r9
        applyStimulus(1'b0, '0, '0, 1'b1, 4'd9, 32'h12345678, 1'b0, '0, 1'b0, {4'd0, 4'd0, 4'd9});
        idleStep({4'd0, 4'd0, 4'd9});

        // Out-of-range register 15: reads zero, writes and issues are no-ops
        applyStimulus(1'b1, 4'd15, 32'hDEAD, 1'b1, 4'd15, 32'hBEEF, 1'b1, 4'd15, 1'b0, {4'd15, 4'd14, 4'd15});
        idleStep({4'd15, 4'd14, 4'd15});

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                doReset();
            end else begin
                ra = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
                applyStimulus($urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
                              $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), DW'($urandom),
                              $urandom_range(0, 1) == 0, AW'($urandom_range(0, 15)),
                              $urandom_range(0, 24) == 0, ra);
            end
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
